gate_tester: RTL and testbench

GATE_TESTER -- requirements
Module: gate_tester

---
 rtl/gate_tester.sv | 167 ++++++++++++++++
 tb/tb_gate_tester.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_tester.sv
`default_nettype none
// ============================================================================
// Module      : gate_tester
// Description : Self-running pattern tester for a combinational gate model.
//               A 21-bit Fibonacci LFSR drives the model inputs, every
//               response is folded into a 16-bit MISR after a settle delay,
//               and the run ends after PAT_COUNT patterns.
//               Optional golden-signature compare: GATE_TESTER_GOLDEN_CMP_EN
//               adds pass/fail outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_tester #(
    parameter int          PAT_COUNT  = 1000,
    parameter int          SETTLE     = 2,
    parameter logic [20:0] SEED       = 21'h000001,
    parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [20:0] pat_out,
    input  logic [9:0]  resp_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] pat_idx,
    output logic [15:0] signature
`ifdef GATE_TESTER_GOLDEN_CMP_EN
    ,
    output logic        pass,
    output logic        fail
`endif
);

    // An all-zero LFSR would lock up, so a zero seed falls back to 1.
    localparam logic [20:0] c_seed        = (SEED == 21'd0) ? 21'h000001 : SEED;
    localparam logic [15:0] c_pat_count   = 16'(PAT_COUNT);
    localparam logic [3:0]  c_settle_last = 4'(SETTLE - 1);
    localparam int          c_sig_w       = $bits(GOLDEN_SIG);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [20:0]        r_lfsr;
    logic [c_sig_w-1:0] r_misr;
    logic [15:0]        r_pat_idx;
    logic [3:0]         r_settle;
    logic               r_busy;
    logic               r_done;

    logic [20:0]        w_lfsr_next;
    logic [c_sig_w-1:0] w_misr_next;
    logic [15:0]        w_pat_idx_next;
    logic               w_last;
    logic               w_start_ok;

    // Next-value logic for the pattern generator, compactor and counter.
    always_comb begin
        w_lfsr_next    = {r_lfsr[19:0], r_lfsr[20] ^ r_lfsr[18]};
        w_misr_next    = {r_misr[14:0], 1'b0}
                       ^ (r_misr[15] ? 16'h1021 : 16'h0000)
                       ^ {6'b0, resp_in};
        w_pat_idx_next = r_pat_idx + 16'd1;
        w_last         = (w_pat_idx_next == c_pat_count);
        // Abort beats a coincident start.
        w_start_ok     = start && !abort;
    end

    // Main sequencer: state, pattern generator, MISR and registered status.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_lfsr    <= 21'd0;
            r_misr    <= '0;
            r_pat_idx <= 16'd0;
            r_settle  <= 4'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_APPLY;
                        r_lfsr    <= c_seed;
                        r_misr    <= '0;
                        r_pat_idx <= 16'd0;
                        r_settle  <= 4'd0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_settle <= r_settle + 4'd1;
                        if (r_settle == c_settle_last) begin
                            r_state <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_misr    <= w_misr_next;
                        r_lfsr    <= w_lfsr_next;
                        r_pat_idx <= w_pat_idx_next;
                        r_settle  <= 4'd0;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_APPLY;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GATE_TESTER_GOLDEN_CMP_EN
    logic r_pass;
    logic r_fail;

    // Golden compare: latched on the capture that ends the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_start_ok) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if (r_busy && abort) begin
            r_pass <= 1'b0;
            r_fail <= 1'b0;
        end else if ((r_state == ST_CAPTURE) && w_last) begin
            r_pass <= (w_misr_next == GOLDEN_SIG);
            r_fail <= (w_misr_next != GOLDEN_SIG);
        end
    end

    assign pass = r_pass;
    assign fail = r_fail;
`endif

    assign pat_out   = r_lfsr;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pat_idx   = r_pat_idx;
    assign signature = r_misr;

endmodule
`default_nettype wire

// File: tb/tb_gate_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_tester
// Description : Self-checking bench for gate_tester. Instance A runs several
//               patterns with random responses against a reference model;
//               instance B is the single-pattern configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_tester;

    localparam int A_PC = 8;
    localparam int A_S  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, abort_a, start_b, abort_b;
    logic [9:0]  resp_a, resp_b;
    logic [20:0] pat_a, pat_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] idx_a, sig_a, idx_b, sig_b;
`ifdef GATE_TESTER_GOLDEN_CMP_EN
    logic        pass_a, fail_a, pass_b, fail_b;
`endif

    int tests = 0;
    int fails = 0;

    gate_tester #(.PAT_COUNT(A_PC), .SETTLE(A_S), .SEED(21'h0), .GOLDEN_SIG(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .pat_out(pat_a), .resp_in(resp_a), .busy(busy_a), .done(done_a),
        .pat_idx(idx_a), .signature(sig_a)
`ifdef GATE_TESTER_GOLDEN_CMP_EN
        , .pass(pass_a), .fail(fail_a)
`endif
    );

    gate_tester #(.PAT_COUNT(1), .SETTLE(1), .SEED(21'h1), .GOLDEN_SIG(16'h03FF)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .pat_out(pat_b), .resp_in(resp_b), .busy(busy_b), .done(done_b),
        .pat_idx(idx_b), .signature(sig_b)
`ifdef GATE_TESTER_GOLDEN_CMP_EN
        , .pass(pass_b), .fail(fail_b)
`endif
    );

    initial forever #5 clk = ~clk;

    // Reference rules: x^21+x^19+1 shift-left LFSR, CRC-style 16-bit MISR.
    function automatic int lfsr_model(input int x);
        return ((x << 1) & 'h1FFFFF) | (((x >> 20) ^ (x >> 18)) & 1);
    endfunction

    function automatic int misr_model(input int m, input int r);
        int n;
        n = (m << 1) & 'hFFFF;
        if ((m & 'h8000) != 0) n = n ^ 'h1021;
        return n ^ r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One run on instance A; optionally abort (with start) or reset at the
    // first APPLY cycle of pattern abort_at / rst_at.
    task automatic run_a(input int abort_at, input int rst_at);
        int m, lf, p, phase, r;
        m  = 0;
        lf = 1;
        p  = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("a_first_pattern", pat_a, 32'h1);
        for (int t = 0; t < A_PC * (A_S + 1); t++) begin
            phase = t % (A_S + 1);
            if (p == abort_at && phase == 0) begin
                abort_a = 1'b1;
                start_a = 1'b1;
                tick();
                abort_a = 1'b0;
                start_a = 1'b0;
                chk("abort_busy", busy_a, 0);
                chk("abort_done", done_a, 0);
                chk("abort_idx", idx_a, p);
                chk("abort_sig", sig_a, m);
                return;
            end
            if (p == rst_at && phase == 0) begin
                rst     = 1'b1;
                start_a = 1'b1;
                tick();
                rst     = 1'b0;
                start_a = 1'b0;
                chk("rst_pat", pat_a, 0);
                chk("rst_busy", busy_a, 0);
                chk("rst_done", done_a, 0);
                chk("rst_idx", idx_a, 0);
                chk("rst_sig", sig_a, 0);
                return;
            end
            chk("run_busy", busy_a, 1);
            chk("run_done", done_a, 0);
            chk("run_pat", pat_a, lf);
            chk("run_idx", idx_a, p);
            chk("run_sig", sig_a, m);
            r       = int'($urandom_range(0, 1023));
            resp_a  = 10'(r);
            start_a = ($urandom_range(0, 3) == 0);
            if (phase == A_S) begin
                m  = misr_model(m, r);
                lf = lfsr_model(lf);
                p++;
            end
            tick();
        end
        start_a = 1'b0;
        chk("end_done", done_a, 1);
        chk("end_busy", busy_a, 0);
        chk("end_idx", idx_a, A_PC);
        chk("end_sig", sig_a, m);
        for (int k = 0; k < 3; k++) begin
            resp_a = 10'($urandom_range(0, 1023));
            tick();
            chk("hold_done", done_a, 1);
            chk("hold_sig", sig_a, m);
            chk("hold_idx", idx_a, A_PC);
        end
    endtask

    // Single-pattern run on instance B with a fixed response.
    task automatic run_b(input int r);
        resp_b  = 10'(r);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b_apply_busy", busy_b, 1);
        tick();
        chk("b_capture_busy", busy_b, 1);
        chk("b_capture_done", done_b, 0);
        tick();
        chk("b_done", done_b, 1);
        chk("b_busy", busy_b, 0);
        chk("b_idx", idx_b, 1);
        chk("b_sig", sig_b, misr_model(0, r));
`ifdef GATE_TESTER_GOLDEN_CMP_EN
        chk("b_pass", pass_b, (r == 'h3FF) ? 1 : 0);
        chk("b_fail", fail_b, (r == 'h3FF) ? 0 : 1);
`endif
    endtask

    initial begin
        rst     = 1'b1;
        start_a = 1'b0;
        abort_a = 1'b0;
        start_b = 1'b0;
        abort_b = 1'b0;
        resp_a  = 10'h0;
        resp_b  = 10'h0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_pat", pat_a, 0);
        chk("reset_busy", busy_a, 0);
        chk("reset_done", done_a, 0);
        chk("reset_idx", idx_a, 0);
        chk("reset_sig", sig_a, 0);
`ifdef GATE_TESTER_GOLDEN_CMP_EN
        chk("reset_pass", pass_a, 0);
        chk("reset_fail", fail_a, 0);
`endif

        // Full run, restart from DONE with abort at pattern 5.
        run_a(-1, -1);
        run_a(5, -1);

        // Abort while idle changes nothing.
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("idle_abort_busy", busy_a, 0);
        chk("idle_abort_done", done_a, 0);
        chk("idle_abort_idx", idx_a, 5);

        // Reset mid-run at pattern 3, then a clean run.
        run_a(-1, 3);
        run_a(-1, -1);

        // Single-pattern runs: zero response, then all ones.
        run_b(0);
        run_b('h3FF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
